// File: rtl/reg_bank_pkg.sv
// Shared constants and address-decode helpers for the banked register file.
package reg_bank_pkg;

  localparam int unsigned DEF_DATA_WIDTH    = 8;
  localparam int unsigned DEF_NUM_BANKS     = 4;
  localparam int unsigned DEF_BANK_REGS     = 4;
  localparam int unsigned DEF_DOUBLE_BUFFER = 1;

  function automatic int unsigned addr_bits(input int unsigned nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  localparam int unsigned REG_BITS   = $clog2(DEF_BANK_REGS);
  localparam int unsigned ADDR_WIDTH = addr_bits(DEF_NUM_BANKS * DEF_BANK_REGS);

  function automatic int unsigned bank_of(input int unsigned addr,
                                          input int unsigned reg_bits,
                                          input int unsigned num_banks);
    return (addr >> reg_bits) & (num_banks - 1);
  endfunction

  function automatic int unsigned reg_of(input int unsigned addr,
                                         input int unsigned bank_regs);
    return addr & (bank_regs - 1);
  endfunction

endpackage

// File: rtl/reg_bank_array_rise_detect.sv
// Rising-edge detector on a level strobe: 2-bit sample history, one-cycle pulse.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level_i,
  output logic rise_o
);

  logic [1:0] hist_q, hist_d;
  logic       primed_q;

  // The first sample after reset fills both history bits, so a level that is
  // already high at release never looks like a 0->1 transition.
  always_comb begin
    hist_d = {(primed_q ? hist_q[0] : level_i), level_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q   <= '0;
      primed_q <= 1'b0;
    end else begin
      hist_q   <= hist_d;
      primed_q <= 1'b1;
    end
  end

  assign rise_o = (hist_q == 2'b01);

endmodule

// File: rtl/reg_bank_array.sv
// Banked register file fed by the serial receiver; optional shadow copy per bank
// committed atomically when the bank's top register is written.
module reg_bank_array #(
  parameter  int unsigned DATA_WIDTH    = reg_bank_pkg::DEF_DATA_WIDTH,
  parameter  int unsigned NUM_BANKS     = reg_bank_pkg::DEF_NUM_BANKS,
  parameter  int unsigned BANK_REGS     = reg_bank_pkg::DEF_BANK_REGS,
  parameter  int unsigned DOUBLE_BUFFER = reg_bank_pkg::DEF_DOUBLE_BUFFER,
  localparam int unsigned ADDR_WIDTH    = reg_bank_pkg::addr_bits(NUM_BANKS * BANK_REGS)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [ADDR_WIDTH-1:0]                 uart_addr,
  input  logic [DATA_WIDTH-1:0]                 uart_data,
  input  logic                                  uart_ready,
  input  logic [ADDR_WIDTH-1:0]                 rd_addr,
  output logic [DATA_WIDTH-1:0]                 rd_data,
  output logic [NUM_BANKS*BANK_REGS*DATA_WIDTH-1:0] reg_data,
  output logic [NUM_BANKS-1:0]                  reg_event,
  output logic [NUM_BANKS-1:0]                  bank_pending
);
  import reg_bank_pkg::*;

  localparam int unsigned NREGS     = NUM_BANKS * BANK_REGS;
  localparam int unsigned LREG_BITS = $clog2(BANK_REGS);
  localparam int unsigned BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  logic                  wr_evt;
  logic [DATA_WIDTH-1:0] active_q [NREGS];
  logic [DATA_WIDTH-1:0] active_d [NREGS];
  logic [DATA_WIDTH-1:0] bank_src [NREGS];
  logic [NUM_BANKS-1:0]  pending_q, pending_d;
  logic [NUM_BANKS-1:0]  event_q, event_d;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [BANK_BITS-1:0]  wbank;
  logic                  top_reg;

  rise_detect u_rise (
    .clk     (clk),
    .rst_n   (rst_n),
    .level_i (uart_ready),
    .rise_o  (wr_evt)
  );

  always_comb begin
    wbank   = BANK_BITS'(bank_of(32'(uart_addr), LREG_BITS, NUM_BANKS));
    top_reg = (reg_of(32'(uart_addr), BANK_REGS) == BANK_REGS - 1);
  end

  // bank_src is the post-write image of every register; a commit copies the
  // written bank from it, so the top-register data lands on the same edge.
  generate
    if (DOUBLE_BUFFER != 0) begin : g_shadow
      logic [DATA_WIDTH-1:0] shadow_q [NREGS];
      logic [DATA_WIDTH-1:0] shadow_d [NREGS];

      always_comb begin
        shadow_d = shadow_q;
        if (wr_evt) shadow_d[uart_addr] = uart_data;
        bank_src = shadow_d;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned n = 0; n < NREGS; n++) shadow_q[n] <= '0;
        end else begin
          shadow_q <= shadow_d;
        end
      end
    end else begin : g_direct
      always_comb begin
        bank_src = active_q;
        if (wr_evt) bank_src[uart_addr] = uart_data;
      end
    end
  endgenerate

  always_comb begin
    active_d  = active_q;
    pending_d = pending_q;
    event_d   = '0;
    if (wr_evt) begin
      if (top_reg || DOUBLE_BUFFER == 0) begin
        for (int unsigned n = 0; n < NREGS; n++) begin
          if (BANK_BITS'(n / BANK_REGS) == wbank) active_d[n] = bank_src[n];
        end
      end
      if (top_reg) event_d[wbank] = 1'b1;
      if (DOUBLE_BUFFER != 0) pending_d[wbank] = !top_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned n = 0; n < NREGS; n++) active_q[n] <= '0;
      pending_q <= '0;
      event_q   <= '0;
      rd_data_q <= '0;
    end else begin
      active_q  <= active_d;
      pending_q <= pending_d;
      event_q   <= event_d;
      rd_data_q <= active_q[rd_addr];
    end
  end

  generate
    for (genvar g = 0; g < NREGS; g++) begin : g_flat
      assign reg_data[g*DATA_WIDTH +: DATA_WIDTH] = active_q[g];
    end
  endgenerate

  assign rd_data      = rd_data_q;
  assign reg_event    = event_q;
  assign bank_pending = pending_q;

endmodule

// File: tb/tb_reg_bank_array.sv
// Directed bench for reg_bank_array: default buffered build, direct-write build,
// and a 12-bit/2-bank/8-register build driven from shared address/data buses.
module tb_reg_bank_array;

  logic         clk = 1'b0;
  logic         rst_a, rst_b, rst_c;
  logic [3:0]   addr, rd_addr;
  logic [11:0]  data;
  logic [2:0]   rdy;

  logic [7:0]   rd_a, rd_b;
  logic [11:0]  rd_c;
  logic [127:0] reg_a, reg_b;
  logic [191:0] reg_c;
  logic [3:0]   ev_a, ev_b, pend_a, pend_b;
  logic [1:0]   ev_c, pend_c;

  int checks   = 0;
  int failures = 0;
  int n_ev;
  logic [7:0] rd_at_ev;

  always #5 clk = ~clk;

  reg_bank_array u_a (
    .clk(clk), .rst_n(rst_a), .uart_addr(addr), .uart_data(data[7:0]),
    .uart_ready(rdy[0]), .rd_addr(rd_addr), .rd_data(rd_a), .reg_data(reg_a),
    .reg_event(ev_a), .bank_pending(pend_a)
  );

  reg_bank_array #(.DOUBLE_BUFFER(0)) u_b (
    .clk(clk), .rst_n(rst_b), .uart_addr(addr), .uart_data(data[7:0]),
    .uart_ready(rdy[1]), .rd_addr(rd_addr), .rd_data(rd_b), .reg_data(reg_b),
    .reg_event(ev_b), .bank_pending(pend_b)
  );

  reg_bank_array #(.DATA_WIDTH(12), .NUM_BANKS(2), .BANK_REGS(8)) u_c (
    .clk(clk), .rst_n(rst_c), .uart_addr(addr), .uart_data(data),
    .uart_ready(rdy[2]), .rd_addr(rd_addr), .rd_data(rd_c), .reg_data(reg_c),
    .reg_event(ev_c), .bank_pending(pend_c)
  );

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One write: ready high for one cycle; returns at the negedge after the sampling edge.
  task automatic write(input int sel, input logic [3:0] a, input logic [11:0] d);
    @(negedge clk);
    addr = a;
    data = d;
    rdy[sel] = 1'b1;
    @(negedge clk);
    rdy[sel] = 1'b0;
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    rdy = 3'b001; addr = '0; data = '0; rd_addr = '0;

    #12;
    chk("rst_reg_a",  192'(reg_a),  '0);
    chk("rst_rd_a",   192'(rd_a),   '0);
    chk("rst_ev_a",   192'(ev_a),   '0);
    chk("rst_pend_a", 192'(pend_a), '0);
    chk("rst_reg_c",  192'(reg_c),  '0);

    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rel_high_ev",  192'(ev_a),  '0);
      chk("rel_high_reg", 192'(reg_a), '0);
    end
    rdy[0] = 1'b0;

    write(0, 4'd4, 12'h11);
    write(0, 4'd5, 12'h22);
    write(0, 4'd6, 12'h33);
    @(negedge clk);
    chk("shadow_hidden", 192'(reg_a),  '0);
    chk("pending_b1",    192'(pend_a), 192'(4'b0010));

    write(0, 4'd7, 12'h44);
    chk("pre_commit",    192'(reg_a),  '0);
    @(negedge clk);
    chk("commit_data",   192'(reg_a),  192'(128'h44332211_00000000));
    chk("commit_ev",     192'(ev_a),   192'(4'b0010));
    chk("commit_pend",   192'(pend_a), '0);
    @(negedge clk);
    chk("ev_one_cycle",  192'(ev_a),   '0);

    write(0, 4'd1, 12'hAA);
    write(0, 4'd15, 12'h5A);
    @(negedge clk);
    chk("iso_ev",   192'(ev_a),   192'(4'b1000));
    chk("iso_data", 192'(reg_a),  192'(128'h5A000000_00000000_44332211_00000000));
    chk("iso_pend", 192'(pend_a), 192'(4'b0001));

    rd_addr = 4'd7;
    @(negedge clk);
    chk("rd_7", 192'(rd_a), 192'(8'h44));
    rd_addr = 4'd6;
    @(negedge clk);
    chk("rd_6", 192'(rd_a), 192'(8'h33));

    // Held ready: one write only; read of the same address on the write edge sees the old value.
    rd_addr = 4'd11;
    @(negedge clk);
    addr = 4'd11; data = 12'h77; rdy[0] = 1'b1;
    n_ev = 0; rd_at_ev = 8'hFF;
    repeat (10) begin
      @(negedge clk);
      if (ev_a != 4'b0000) begin
        n_ev++;
        rd_at_ev = rd_a;
      end
    end
    rdy[0] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (ev_a != 4'b0000) n_ev++;
    end
    chk("held_count",   192'(n_ev),         192'(1));
    chk("held_data",    192'(reg_a[95:64]), 192'(32'h77000000));
    chk("rd_same_edge", 192'(rd_at_ev),     '0);
    chk("rd_after",     192'(rd_a),         192'(8'h77));

    n_ev = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (ev_a[0]) n_ev++;
      addr = 4'd3; data = 12'(i); rdy[0] = 1'b1;
      @(negedge clk);
      if (ev_a[0]) n_ev++;
      rdy[0] = 1'b0;
    end
    repeat (3) begin
      @(negedge clk);
      if (ev_a[0]) n_ev++;
    end
    chk("maxrate_count", 192'(n_ev),         192'(4));
    chk("maxrate_data",  192'(reg_a[31:0]),  192'(32'h0400AA00));
    chk("maxrate_pend",  192'(pend_a),       '0);

    write(1, 4'd2, 12'hC3);
    chk("direct_pre", 192'(reg_b), '0);
    @(negedge clk);
    chk("direct_data", 192'(reg_b),  192'(128'h00C30000));
    chk("direct_ev0",  192'(ev_b),   '0);
    chk("direct_pend", 192'(pend_b), '0);
    write(1, 4'd3, 12'h0F);
    @(negedge clk);
    chk("direct_top_ev",   192'(ev_b),  192'(4'b0001));
    chk("direct_top_data", 192'(reg_b), 192'(128'h0FC30000));

    write(2, 4'd15, 12'hABC);
    @(negedge clk);
    chk("wide_ev",   192'(ev_c),  192'(2'b10));
    chk("wide_data", reg_c,       192'(12'hABC) << 180);
    chk("wide_pend", 192'(pend_c), '0);
    rd_addr = 4'd15;
    @(negedge clk);
    chk("wide_rd", 192'(rd_c), 192'(12'hABC));

    write(2, 4'd0, 12'h123);
    @(negedge clk);
    chk("wide_pend0", 192'(pend_c), 192'(2'b01));
    @(posedge clk);
    #2 rst_c = 1'b0;
    #1;
    chk("async_rst_reg",  reg_c,          '0);
    chk("async_rst_rd",   192'(rd_c),     '0);
    chk("async_rst_pend", 192'(pend_c),   '0);
    chk("async_rst_ev",   192'(ev_c),     '0);
    @(negedge clk);
    rst_c = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
